// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and stopwatch: field geometry,
// default limits, and the state encoding used for display-mux decode.
package timer_pkg;

  localparam int unsigned FIELD_W  = 6;
  localparam int unsigned PACKED_W = 18;

  localparam int unsigned TICK_LSB = 0;
  localparam int unsigned SEC_LSB  = 6;
  localparam int unsigned MIN_LSB  = 12;

  localparam int unsigned MIN_MAX_DEF  = 23;
  localparam int unsigned SEC_MAX_DEF  = 59;
  localparam int unsigned TICK_MAX_DEF = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAUSE   = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } timer_state_e;

  function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v,
                                                     input int unsigned max);
    if (32'(v) > max) return FIELD_W'(max);
    return v;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the mode controller (master) and countdown_timer (slave).
interface countdown_timer_if;
  import timer_pkg::*;

  logic [1:0]          mode;
  logic                start_pause;
  logic                clr;
  logic                load;
  logic [PACKED_W-1:0] preset;
  logic [PACKED_W-1:0] clock;
  logic                expired;
  logic                busy;

  modport master (
    output mode, start_pause, clr, load, preset,
    input  clock, expired, busy
  );

  modport slave (
    input  mode, start_pause, clr, load, preset,
    output clock, expired, busy
  );
endinterface

// File: rtl/timer_field_dec.sv
// One mixed-radix digit of the countdown: load, or decrement with wrap to MAX and borrow out.
module timer_field_dec
  import timer_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic [FIELD_W-1:0] value,
  input  logic               borrow_in,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_value,
  output logic [FIELD_W-1:0] next_value,
  output logic               borrow_out
);

  localparam logic [FIELD_W-1:0] MAX_V = FIELD_W'(MAX);

  always_comb begin
    next_value = value;
    if (load) begin
      next_value = load_value;
    end else if (borrow_in) begin
      next_value = (value == '0) ? MAX_V : value - FIELD_W'(1);
    end
  end

  assign borrow_out = borrow_in && (value == '0);

endmodule

// File: rtl/countdown_timer.sv
// Preset countdown timer (min/sec/tick), active only when mode == MODE_SEL.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN to reload the last preset on expiry instead of stopping.
module countdown_timer
  import timer_pkg::*;
#(
  parameter logic [1:0]  MODE_SEL = 2'b11,
  parameter int unsigned MIN_MAX  = MIN_MAX_DEF,
  parameter int unsigned SEC_MAX  = SEC_MAX_DEF,
  parameter int unsigned TICK_MAX = TICK_MAX_DEF
) (
  input logic              clk,
  input logic              rst_n,
  countdown_timer_if.slave bus
);

  timer_state_e        state_q, state_d;
  logic [PACKED_W-1:0] count_q, count_d;
  logic                expired_q, expired_d;
  logic [PACKED_W-1:0] load_val, dec_next;
  logic                active, dec_en, fld_load;
  logic                tick_borrow, sec_borrow, min_borrow;
  logic                hit_zero;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [PACKED_W-1:0] shadow_q, shadow_d;
`endif

  assign load_val = {clamp_field(bus.preset[MIN_LSB  +: FIELD_W], MIN_MAX),
                     clamp_field(bus.preset[SEC_LSB  +: FIELD_W], SEC_MAX),
                     clamp_field(bus.preset[TICK_LSB +: FIELD_W], TICK_MAX)};

  assign active   = (bus.mode == MODE_SEL);
  assign fld_load = active && !bus.clr && bus.load;
  assign dec_en   = active && !bus.clr && !bus.load && (state_q == RUN) && !bus.start_pause;

  timer_field_dec #(.MAX(TICK_MAX)) u_tick (
    .value      (count_q[TICK_LSB +: FIELD_W]),
    .borrow_in  (dec_en),
    .load       (fld_load),
    .load_value (load_val[TICK_LSB +: FIELD_W]),
    .next_value (dec_next[TICK_LSB +: FIELD_W]),
    .borrow_out (tick_borrow)
  );

  timer_field_dec #(.MAX(SEC_MAX)) u_sec (
    .value      (count_q[SEC_LSB +: FIELD_W]),
    .borrow_in  (tick_borrow),
    .load       (fld_load),
    .load_value (load_val[SEC_LSB +: FIELD_W]),
    .next_value (dec_next[SEC_LSB +: FIELD_W]),
    .borrow_out (sec_borrow)
  );

  timer_field_dec #(.MAX(MIN_MAX)) u_min (
    .value      (count_q[MIN_LSB +: FIELD_W]),
    .borrow_in  (sec_borrow),
    .load       (fld_load),
    .load_value (load_val[MIN_LSB +: FIELD_W]),
    .next_value (dec_next[MIN_LSB +: FIELD_W]),
    .borrow_out (min_borrow)
  );

  // A minute underflow cannot occur from a nonzero count; treat it as expiry defensively.
  assign hit_zero = (dec_next == '0) || min_borrow;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = expired_q;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    shadow_d  = shadow_q;
`endif
    if (active) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      expired_d = 1'b0;
`endif
      if (bus.clr) begin
        state_d   = IDLE;
        count_d   = '0;
        expired_d = 1'b0;
      end else if (bus.load) begin
        count_d   = dec_next;
        expired_d = 1'b0;
        state_d   = (load_val == '0) ? IDLE : PAUSE;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        shadow_d  = load_val;
`endif
      end else begin
        unique case (state_q)
          IDLE:    count_d = '0;
          PAUSE:   if (!bus.start_pause) state_d = RUN;
          RUN: begin
            if (bus.start_pause) begin
              state_d = PAUSE;
            end else if (hit_zero) begin
              expired_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
              count_d   = shadow_q;
`else
              count_d   = '0;
              state_d   = EXPIRED;
`endif
            end else begin
              count_d = dec_next;
            end
          end
          EXPIRED: count_d = '0;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      shadow_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      shadow_q  <= shadow_d;
`endif
    end
  end

  assign bus.clock   = count_q;
  assign bus.expired = expired_q;
  assign bus.busy    = (state_q == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer; one table row per clock edge.
module tb_countdown_timer;

  logic clk;
  logic rst_n;
  countdown_timer_if bus ();

  countdown_timer #(
    .MODE_SEL (2'b11),
    .MIN_MAX  (23),
    .SEC_MAX  (59),
    .TICK_MAX (59)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [1:0]  mode;
    logic        sp;
    logic        clr;
    logic        load;
    logic [17:0] preset;
    logic [17:0] e_clock;
    logic        e_exp;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   row      = 0;

  function automatic logic [17:0] p(input int m, input int s, input int t);
    return {6'(m), 6'(s), 6'(t)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [1:0] md, input logic sp,
                              input logic c, input logic l, input logic [17:0] pr,
                              input logic [17:0] ec, input logic ee, input logic eb);
    vec_t v;
    v.rst_n = r; v.mode = md; v.sp = sp; v.clr = c; v.load = l; v.preset = pr;
    v.e_clock = ec; v.e_exp = ee; v.e_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input int r, input logic [17:0] act,
                       input logic [17:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, r, act, exp);
  endtask

  task automatic apply(input vec_t v);
    rst_n           = v.rst_n;
    bus.mode        = v.mode;
    bus.start_pause = v.sp;
    bus.clr         = v.clr;
    bus.load        = v.load;
    bus.preset      = v.preset;
    @(posedge clk);
    #1;
    check("clock",   row, bus.clock,          v.e_clock);
    check("expired", row, 18'(bus.expired),   18'(v.e_exp));
    check("busy",    row, 18'(bus.busy),      18'(v.e_busy));
    row++;
  endtask

  initial begin
    rst_n = 1'b0; bus.mode = 2'b11; bus.start_pause = 1'b1;
    bus.clr = 1'b0; bus.load = 1'b0; bus.preset = '0;

    // reset with load asserted and an all-ones preset
    tbl.push_back(mk(0, 2'b11, 0, 0, 1, 18'h3FFFF, p(0,0,0), 0, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 1, 18'h3FFFF, p(0,0,0), 0, 0));
    // borrow chain
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, p(1,0,0),  p(1,0,0),   0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(1,0,0),   0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,59,59), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,59,58), 0, 1));
    // pause for 5 edges, then mode gate with clr for 4 edges
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, p(0,5,10), p(0,5,10), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,5,10), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,5,9),  0, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 2'b11, 1, 0, 0, '0,      p(0,5,9),  0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 2'b10, 0, 1, 1, p(9,9,9), p(0,5,9), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,5,9),  0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,5,8),  0, 1));
    // clamping, loaded into PAUSE
    tbl.push_back(mk(1, 2'b11, 1, 0, 1, p(30,61,63), p(23,59,59), 0, 0));
    tbl.push_back(mk(1, 2'b11, 1, 0, 0, '0,          p(23,59,59), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,          p(23,59,59), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,          p(23,59,58), 0, 1));
    // load while running returns to PAUSE even with start_pause low
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, p(0,0,1),  p(0,0,1), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,1), 0, 1));
    // load and clr together: clr wins
    tbl.push_back(mk(1, 2'b11, 0, 1, 1, p(5,5,5),  p(0,0,0), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,0), 0, 0));
    // zero preset stays IDLE
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, p(0,0,0),  p(0,0,0), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,0), 0, 0));
    // reset mid-run
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, p(0,0,5),  p(0,0,5), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,5), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,4), 0, 1));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, '0,        p(0,0,0), 0, 0));
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, p(0,0,2),  p(0,0,2), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,2), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,1), 0, 1));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,      p(0,0,2), 1, 1));
      tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,      p(0,0,1), 0, 1));
    end
`else
    // basic countdown 3,3,2,1,0
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, p(0,0,3),  p(0,0,3), 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,3), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,2), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,1), 0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 0, 0, '0,        p(0,0,0), 1, 0));
`endif

    foreach (tbl[i]) apply(tbl[i]);

`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
    // expired holds for 10 edges regardless of start_pause
    for (int i = 0; i < 10; i++)
      apply(mk(1, 2'b11, i[0], 0, 0, '0, p(0,0,0), 1, 0));
    // 00:00:01 expires two edges after the load edge
    apply(mk(1, 2'b11, 0, 0, 1, p(0,0,1), p(0,0,1), 0, 0));
    apply(mk(1, 2'b11, 0, 0, 0, '0,       p(0,0,1), 0, 1));
    apply(mk(1, 2'b11, 0, 0, 0, '0,       p(0,0,0), 1, 0));
    // mode gate holds EXPIRED, then clr leaves it
    apply(mk(1, 2'b01, 0, 1, 0, '0,       p(0,0,0), 1, 0));
    apply(mk(1, 2'b11, 0, 1, 0, '0,       p(0,0,0), 0, 0));
`endif

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown counterpart of the stopwatch: loads a preset min/sec/tick value and counts it down to zero, one tick per clk.
- Raises an expiry flag at zero.
- Output uses the same packed 18-bit {min,sec,tick} format as the stopwatch, so both feed the same display mux.
- Active only when the top-level mode selector equals MODE_SEL.

Parameters:
- MODE_SEL, 2'b11: mode value that enables this block; any other mode freezes it.
- MIN_MAX, 23: largest legal minute value (same minute range as the stopwatch).
- SEC_MAX, 59: largest legal second value.
- TICK_MAX, 59: largest legal tick (sub-second) value.

Ports:
- clk  input  1  system clock; one count step per rising edge while running.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- mode  input  2  top-level mode selector; block is active only when mode == MODE_SEL.
- start_pause  input  1  level input: 0 = run, 1 = pause.
- clr  input  1  1 = clear count to zero and return to IDLE.
- load  input  1  1 = capture preset this cycle.
- preset  input  18  {min[17:12], sec[11:6], tick[5:0]} start value.
- clock  output  18  current count, packed {min, sec, tick}.
- expired  output  1  count has reached zero from a nonzero value.
- busy  output  1  1 while in state RUN.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; clock=0; expired=0; busy=0. Reset overrides everything, including mid-run.
- Input priority each edge: rst_n > mode gate > clr > load > count step.
- Mode gate: if mode != MODE_SEL, all registers hold (state, count, expired); clr, load and start_pause are ignored.
- Outputs come straight from registers: clock, expired and busy change on the same edge as the state/count update.
- clr=1: count=0, state=IDLE, expired=0.
- load=1:
  - Each field is captured with clamping: min>MIN_MAX becomes MIN_MAX; sec>SEC_MAX becomes SEC_MAX; tick>TICK_MAX becomes TICK_MAX.
  - expired is cleared.
  - Next state is IDLE if the clamped value is 0, otherwise PAUSE.
  - No count step occurs in the load cycle.
- States:
  - IDLE: count=0. Stays in IDLE until load.
  - PAUSE: count holds. Goes to RUN on an edge where start_pause==0. The first decrement happens on the edge after entering RUN.
  - RUN: decrements once per edge while start_pause==0.
    - start_pause==1 → PAUSE, with no decrement on that edge.
    - If the decrement makes the count 0 → EXPIRED, and expired=1 on that same edge.
  - EXPIRED: count=0; expired stays 1. Leaves only on load, clr or reset.
- Decrement rule (mixed-radix borrow):
  - tick>0: tick-1.
  - tick==0: tick=TICK_MAX and borrow from sec.
  - sec==0 on borrow: sec=SEC_MAX and borrow from min.
  - min never underflows, because RUN is never entered with count 0.
- Boundary cases:
  - load and clr together: clr wins.
  - load while in RUN: reload the value and go to PAUSE, even if start_pause==0. Counting resumes on the following edge.
  - Preset 00:00:01 with run: expires 2 edges after the load edge (one edge PAUSE→RUN, one decrement).
  - start_pause is level-sensitive; no edge detection is required.

Optional Feature:
- Macro: COUNTDOWN_TIMER_AUTORELOAD_EN.
- Defined:
  - A shadow register holds the last clamped preset.
  - On the edge that reaches 0, the count reloads from the shadow register and the state stays RUN.
  - expired is a single-cycle pulse, and the EXPIRED state is unreachable.
  - A preset of 0 still goes to IDLE.
- Undefined: no shadow register; behaviour is exactly as described above.

Decomposition:
- Shared package timer_pkg, containing:
  - field width 6 and the packed width 18;
  - field bit positions;
  - default limits 23/59/59;
  - the state enum {IDLE, PAUSE, RUN, EXPIRED}, also reusable by the stopwatch for display-mux decode.
- One sub-module, timer_field_dec, instantiated three times:
  - inputs: 6-bit value, parameter MAX, borrow_in, load, load_value;
  - outputs: next value, borrow_out (asserted when value==0 && borrow_in).
  - Clamping is done in the top level before load_value reaches the field.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with load=1 and preset=18'h3FFFF → clock=0, expired=0, busy=0.
- Basic countdown: mode=11; load preset {0,0,3} with start_pause=0.
  - clock sequence after the load edge: 3,3,2,1,0.
  - expired=1 with clock=0 and holds for 10 further edges.
  - busy drops to 0 when expired rises.
- Borrow chain: load {1,0,0} and run → after the first decrement, clock = {0,59,59}; after the next, {0,59,58}.
- Pause and mode gate:
  - RUN at {0,5,10}, then start_pause=1 for 5 edges → clock stays {0,5,9} (one decrement before pause took effect).
  - Then mode=2'b10 with start_pause=0 and clr=1 for 4 edges → no change.
- Clamp and priority:
  - load {30,61,63} → clock={23,59,59}, state PAUSE.
  - load=1 and clr=1 together → clock=0, state IDLE.
- Autoreload (macro defined): load {0,0,2} and run → clock 2,2,1,0→2 on a single edge, with an expired pulse lasting exactly 1 cycle. The sequence repeats every 2 edges.
